// File: rtl/dm_pkg.sv
// Shared constants for the data-memory command port: FSM encodings, dopc bit
// positions and the load/store select encoding used by both LS stage and responder.
package dm_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StDrain = 2'b01,
    StDone  = 2'b10
  } dm_state_e;

  localparam int unsigned DOPC_VALID = 2;
  localparam int unsigned DOPC_SEL   = 1;
  localparam int unsigned DOPC_TERM  = 0;

  localparam logic SEL_LOAD  = 1'b0;
  localparam logic SEL_STORE = 1'b1;

endpackage

// File: rtl/dm_ram_sp.sv
// Single-port synchronous RAM with write enable and enabled, registered read.
// Read is read-first; the array has no reset so it maps onto block RAM.
module dm_ram_sp #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_ls_resp.sv
// Load/store responder: decodes LS commands, range-checks them against the RAM,
// returns load data one cycle later and runs the RUN/DRAIN/DONE termination FSM.
module dm_ls_resp
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk_i_dm,
  input  logic              rst_i_dm,
  input  logic [2:0]        dm_dopc_i_dm,
  input  logic [ADDR_W-1:0] dm_addr_i_dm,
  input  logic [DATA_W-1:0] dm_wdata_i_dm,
  input  logic              restart_i_dm,
  output logic [DATA_W-1:0] dm_rdata_o_dm,
  output logic              dm_rvalid_o_dm,
  output logic              dm_err_o_dm,
  output logic              dm_done_o_dm,
  output logic              dm_busy_o_dm,
  output logic [15:0]       ld_cnt_o_dm,
  output logic [15:0]       st_cnt_o_dm
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  dm_state_e         state_q;
  logic              rvalid_q, err_q, done_q, busy_q;
  logic              rd_zero_q;
  logic [15:0]       ld_cnt_q, st_cnt_q;
  logic              valid, is_store, term, accept, in_range;
  logic              ld_ok, st_ok;
  logic [DATA_W-1:0] ram_rdata;

  assign valid    = dm_dopc_i_dm[DOPC_VALID];
  assign is_store = (dm_dopc_i_dm[DOPC_SEL] == SEL_STORE);
  assign term     = dm_dopc_i_dm[DOPC_TERM];
  assign accept   = valid && (state_q == StRun) && !rst_i_dm;
  assign in_range = 32'(dm_addr_i_dm) < DEPTH;
  assign ld_ok    = accept && !is_store && in_range;
  assign st_ok    = accept && is_store && in_range;

  dm_ram_sp #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i  (clk_i_dm),
    .we_i   (st_ok),
    .re_i   (ld_ok),
    .addr_i (dm_addr_i_dm[IdxW-1:0]),
    .wdata_i(dm_wdata_i_dm),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk_i_dm) begin
    if (rst_i_dm) begin
      state_q   <= StRun;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rd_zero_q <= 1'b1;
      ld_cnt_q  <= '0;
      st_cnt_q  <= '0;
    end else begin
      rvalid_q <= accept && !is_store;
      err_q    <= accept && !in_range;
      // The RAM read register only moves on in-range loads, so a zero mask
      // covers both reset and out-of-range loads while holding otherwise.
      if (accept && !is_store) begin
        rd_zero_q <= !in_range;
      end

      unique case (state_q)
        StRun: begin
          if (term) begin
            state_q <= StDrain;
            busy_q  <= 1'b1;
          end
        end
        StDrain: begin
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        StDone: begin
          if (restart_i_dm) begin
            state_q <= StRun;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StRun;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase

      if (restart_i_dm) begin
        ld_cnt_q <= '0;
        st_cnt_q <= '0;
      end else begin
        if (ld_ok && ld_cnt_q != 16'hFFFF) ld_cnt_q <= ld_cnt_q + 16'd1;
        if (st_ok && st_cnt_q != 16'hFFFF) st_cnt_q <= st_cnt_q + 16'd1;
      end
    end
  end

  assign dm_rdata_o_dm  = rd_zero_q ? '0 : ram_rdata;
  assign dm_rvalid_o_dm = rvalid_q;
  assign dm_err_o_dm    = err_q;
  assign dm_done_o_dm   = done_q;
  assign dm_busy_o_dm   = busy_q;
  assign ld_cnt_o_dm    = ld_cnt_q;
  assign st_cnt_o_dm    = st_cnt_q;

endmodule

// File: tb/tb_dm_ls_resp.sv
// Scoreboard bench for dm_ls_resp: expected responses are queued at issue time
// and matched against rvalid/err pulses on the falling edge.
module tb_dm_ls_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  dopc = 3'b000;
  logic [13:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        restart = 1'b0;
  logic [15:0] rdata, ld_cnt, st_cnt;
  logic        rvalid, err, done, busy;

  typedef struct packed {
    logic        rv;
    logic        er;
    logic [15:0] data;
  } resp_t;

  resp_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  dm_ls_resp #(
    .DATA_W(16),
    .ADDR_W(14),
    .DEPTH (4096)
  ) dut (
    .clk_i_dm      (clk),
    .rst_i_dm      (rst),
    .dm_dopc_i_dm  (dopc),
    .dm_addr_i_dm  (addr),
    .dm_wdata_i_dm (wdata),
    .restart_i_dm  (restart),
    .dm_rdata_o_dm (rdata),
    .dm_rvalid_o_dm(rvalid),
    .dm_err_o_dm   (err),
    .dm_done_o_dm  (done),
    .dm_busy_o_dm  (busy),
    .ld_cnt_o_dm   (ld_cnt),
    .st_cnt_o_dm   (st_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rs, input logic [2:0] op,
                       input logic [13:0] a, input logic [15:0] wd);
    @(posedge clk);
    #1;
    rst = r; restart = rs; dopc = op; addr = a; wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 14'h0, 16'h0);
  endtask

  task automatic ld(input logic [13:0] a, input logic [15:0] exp_d);
    drive(1'b0, 1'b0, 3'b100, a, 16'h0);
    sb_q.push_back('{rv: 1'b1, er: 1'b0, data: exp_d});
  endtask

  task automatic st(input logic [13:0] a, input logic [15:0] d);
    drive(1'b0, 1'b0, 3'b110, a, d);
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] ld_e, input logic [15:0] st_e);
    check({tag, "_ld_cnt"}, 32'(ld_cnt), 32'(ld_e));
    check({tag, "_st_cnt"}, 32'(st_cnt), 32'(st_e));
  endtask

  // Every rvalid or err pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    resp_t e;
    if (rvalid === 1'b1 || err === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", {14'h0, rvalid, err, rdata}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("resp", {14'h0, rvalid, err, rdata}, {14'h0, e.rv, e.er, e.data});
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0, 3'b000, 14'h0, 16'h0);
    drive(1'b1, 1'b0, 3'b000, 14'h0, 16'h0);
    idle();
    check("rst_outs", {rvalid, err, done, busy, rdata}, 32'h0);
    check_cnt("rst", 16'd0, 16'd0);

    // Store then load same address on the next cycle
    st(14'h0010, 16'h1234);
    ld(14'h0010, 16'h1234);
    idle();
    check_cnt("stld", 16'd1, 16'd1);

    // Preload and back-to-back loads
    st(14'h0000, 16'h000A);
    st(14'h0001, 16'h000B);
    st(14'h0002, 16'h000C);
    ld(14'h0000, 16'h000A);
    ld(14'h0001, 16'h000B);
    ld(14'h0002, 16'h000C);
    idle();
    check("b2b_rvalid", 32'(rvalid), 32'd1);
    check_cnt("b2b", 16'd4, 16'd4);

    // Out-of-range load and store
    drive(1'b0, 1'b0, 3'b100, 14'h1000, 16'h0);
    sb_q.push_back('{rv: 1'b1, er: 1'b1, data: 16'h0});
    st(14'h2000, 16'hFFFF);
    sb_q.push_back('{rv: 1'b0, er: 1'b1, data: 16'h0});
    ld(14'h0000, 16'h000A);
    idle();
    check_cnt("oor", 16'd5, 16'd4);

    // Terminate together with a load
    drive(1'b0, 1'b0, 3'b101, 14'h0010, 16'h0);
    sb_q.push_back('{rv: 1'b1, er: 1'b0, data: 16'h1234});
    idle();
    check("term_t1", {30'h0, busy, done}, 32'h2);
    idle();
    check("term_t2", {30'h0, busy, done}, 32'h1);
    st(14'h0010, 16'h5555);
    drive(1'b0, 1'b0, 3'b100, 14'h0010, 16'h0);
    idle();
    check("done_hold", 32'(done), 32'd1);
    check_cnt("done", 16'd6, 16'd4);

    // Restart from DONE; a load is accepted on the very next cycle
    drive(1'b0, 1'b1, 3'b000, 14'h0, 16'h0);
    ld(14'h0010, 16'h1234);
    check("restart_done", 32'(done), 32'd0);
    check_cnt("restart", 16'd0, 16'd0);
    idle();
    check_cnt("after_restart", 16'd1, 16'd0);

    // Restart in RUN clears counters only, then drive ld_cnt into saturation
    drive(1'b0, 1'b1, 3'b000, 14'h0, 16'h0);
    ld(14'h0001, 16'h000B);
    check("run_restart_state", {30'h0, busy, done}, 32'h0);
    check_cnt("run_restart", 16'd0, 16'd0);
    for (int i = 1; i < 32'hFFFE; i++) ld(14'h0001, 16'h000B);
    ld(14'h0001, 16'h000B);
    check("sat_pre", 32'(ld_cnt), 32'hFFFE);
    ld(14'h0001, 16'h000B);
    ld(14'h0001, 16'h000B);
    idle();
    check("sat_hold", 32'(ld_cnt), 32'hFFFF);

    // Reset mid-run with a store and a load in the reset cycles
    drive(1'b1, 1'b0, 3'b110, 14'h0010, 16'h7777);
    drive(1'b1, 1'b0, 3'b100, 14'h0010, 16'h0);
    idle();
    check("midrst_outs", {rvalid, err, done, busy, rdata}, 32'h0);
    check_cnt("midrst", 16'd0, 16'd0);
    ld(14'h0010, 16'h1234);
    idle();
    idle();
    check_cnt("post_rst", 16'd1, 16'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_ls_resp.md
# dm_ls_resp

Data-memory responder for the load/store command port. It consumes the 3-bit data-memory opcode and 14-bit address driven by the execution unit's LS stage, and performs single-port synchronous load/store accesses. It returns load data with fixed one-cycle latency and tracks program termination through a small run/drain/done state machine. It sits between Exe0's LS stage and the data-memory array, one instance per integer lane.

## Interface
Parameters:
- DATA_W, 16, data word width
- ADDR_W, 14, address width (matches LS address output)
- DEPTH, 4096, implemented words; addresses >= DEPTH are out of range

Ports:
- clk_i_dm  in  1  clock
- rst_i_dm  in  1  reset, synchronous, active-high
- dm_dopc_i_dm  in  3  {valid, sel_ls (0 load, 1 store), terminate}
- dm_addr_i_dm  in  ADDR_W  access address
- dm_wdata_i_dm  in  DATA_W  store data, sampled with a valid store
- restart_i_dm  in  1  leave DONE, clear counters
- dm_rdata_o_dm  out  DATA_W  load data
- dm_rvalid_o_dm  out  1  load data valid pulse
- dm_err_o_dm  out  1  out-of-range access pulse
- dm_done_o_dm  out  1  high while in DONE
- dm_busy_o_dm  out  1  high in DRAIN
- ld_cnt_o_dm  out  16  accepted in-range loads, saturating
- st_cnt_o_dm  out  16  accepted in-range stores, saturating

## Operation
- Decode: valid=dopc[2], store=dopc[1], term=dopc[0]. The access is accepted only when valid=1 and state=RUN.
- Accepted store, in range: mem[addr] <= wdata at that edge; st_cnt+1 (saturates at 0xFFFF).
- Accepted load, in range: rdata <= mem[addr]; rvalid=1 next cycle; ld_cnt+1 (saturating).
- Out of range (addr >= DEPTH), accepted: store suppressed; a load returns rdata=0 with rvalid=1; err=1 next cycle; counters unchanged.
- No load: rdata holds its last value; rvalid=0.
- Only one access per cycle. A load in the cycle after a store to the same address returns the new data.
- State machine (2-bit state, encodings in package):
  - RUN: accepts accesses. term=1 -> DRAIN. If valid=1 in the same cycle, the access is performed first.
  - DRAIN: one cycle, busy=1, commands ignored, any pending rvalid completes -> DONE.
  - DONE: done=1, all commands ignored (no write, no rvalid, no err). restart=1 -> RUN, clear both counters.
- restart in RUN/DRAIN: clears counters only; state unchanged.
- Reset: state=RUN. rdata=0, rvalid=0, err=0, done=0, busy=0, counters=0. Memory contents are not reset.

## Timing
- Load latency 1 cycle, command edge -> rdata/rvalid registered outputs.
- Store commits at the command edge. It is visible to a load issued the next cycle, with data out the cycle after that.
- err aligns with the cycle rvalid would appear.
- term in RUN at cycle t: busy=1 at t+1, done=1 from t+2.
- restart in DONE at t: done=0 and counters=0 at t+1; accepts commands from t+1.
- Reset mid-access: a load issued in the reset cycle produces no rvalid. A store in the reset cycle is suppressed.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Shared package dm_pkg: state encodings RUN/DRAIN/DONE, dopc bit indices (DOPC_VALID=2, DOPC_SEL=1, DOPC_TERM=0), and the load/store sel encoding. The LS stage imports the same constants.
- One sub-module: dm_ram_sp. It is a single-port synchronous RAM, DEPTH x DATA_W, with write-enable and registered read, and is inferable as BRAM.
- The FSM, range check and counters live in dm_ls_resp.

## Test plan
- Store/load: store 0x1234 @0x0010, next cycle load @0x0010 -> rvalid=1 and rdata=0x1234 one cycle later; st_cnt=1, ld_cnt=1.
- Back-to-back loads @0x0000, 0x0001, 0x0002 (preloaded 0xA, 0xB, 0xC) -> rvalid high 3 consecutive cycles, rdata 0xA, 0xB, 0xC.
- Out of range: load @0x1000 (DEPTH=4096) -> rvalid=1, rdata=0, err=1; store 0xFFFF @0x2000 then load @0x0000 -> mem[0] unchanged; counters unchanged.
- Terminate with a load (dopc=3'b101 @0x0010) at t -> rvalid at t+1, busy at t+1, done from t+2. Then stores 0x5555 @0x0010 are ignored. restart -> done=0, counters 0, and a load @0x0010 returns the pre-terminate value.
- Counter saturation: force ld_cnt to 0xFFFE, issue 3 loads -> ld_cnt holds 0xFFFF.
- Reset mid-run: assert rst with a valid load -> no rvalid next cycle; all outputs 0 and state RUN; a subsequent load works.
